// File: rtl/bp_pkg.sv
// Shared types and constants for the branch direction predictor: the 2-bit
// saturating counter type, its four named states and the default table size.
package bp_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'b00;
  localparam cnt_t CNT_WNT = 2'b01;
  localparam cnt_t CNT_WT  = 2'b10;
  localparam cnt_t CNT_ST  = 2'b11;

  localparam int BP_INDEX_WIDTH = 6;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter:
// taken moves toward strongly-taken, not-taken toward strongly-not-taken.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    case (cnt_t'(cnt_i))
      CNT_SNT: cnt_o = taken_i ? CNT_WNT : CNT_SNT;
      CNT_WNT: cnt_o = taken_i ? CNT_WT  : CNT_SNT;
      CNT_WT:  cnt_o = taken_i ? CNT_ST  : CNT_WNT;
      CNT_ST:  cnt_o = taken_i ? CNT_ST  : CNT_WT;
      default: cnt_o = cnt_i;
    endcase
  end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table predictor: turns the fetch parser's next PC into the final
// predicted next PC. Define BHT_GSHARE_EN to XOR a resolution-time global history into the index.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH = BP_INDEX_WIDTH,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [31:0]            pc_i,
  input  logic [31:0]            parser_pc_next_i,
  input  logic                   is_branch_i,
  output logic [31:0]            pc_next_o,
  output logic                   pred_taken_o,
  output logic [INDEX_WIDTH-1:0] pred_index_o,
  input  logic                   update_en_i,
  input  logic [INDEX_WIDTH-1:0] update_index_i,
  input  logic                   update_taken_i,
  input  logic                   mispredict_i,
  output logic [CNT_WIDTH-1:0]   branch_cnt_o,
  output logic [CNT_WIDTH-1:0]   miss_cnt_o
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  cnt_t                   cnt_table [ENTRIES];
  logic [ENTRIES-1:0]     wr_en;
  logic [INDEX_WIDTH-1:0] idx;
  cnt_t                   rd_cnt;
  logic [1:0]             upd_next;
  logic [CNT_WIDTH-1:0]   branch_cnt_reg;
  logic [CNT_WIDTH-1:0]   miss_cnt_reg;

`ifdef BHT_GSHARE_EN
  logic [INDEX_WIDTH-1:0] ghr_reg;

  // History advances only on resolved branches, so it never needs repair.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_reg <= '0;
    end else if (update_en_i) begin
      ghr_reg <= {ghr_reg[INDEX_WIDTH-2:0], update_taken_i};
    end
  end

  assign idx = pc_i[INDEX_WIDTH+1:2] ^ ghr_reg;
`else
  assign idx = pc_i[INDEX_WIDTH+1:2];
`endif

  // Prediction reads the registered table directly: a same-cycle update is not bypassed.
  assign rd_cnt       = cnt_table[idx];
  assign pred_index_o = idx;
  assign pred_taken_o = is_branch_i & rd_cnt[1];
  assign pc_next_o    = (is_branch_i & ~rd_cnt[1]) ? pc_i + 32'd4 : parser_pc_next_i;

  sat_counter2 u_sat (
    .cnt_i   (cnt_table[update_index_i]),
    .taken_i (update_taken_i),
    .cnt_o   (upd_next)
  );

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign wr_en[gi] = update_en_i && (update_index_i == INDEX_WIDTH'(gi));

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_table[gi] <= CNT_WNT;
        end else if (wr_en[gi]) begin
          cnt_table[gi] <= upd_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_reg <= '0;
      miss_cnt_reg   <= '0;
    end else if (update_en_i) begin
      branch_cnt_reg <= branch_cnt_reg + CNT_WIDTH'(1);
      if (mispredict_i) begin
        miss_cnt_reg <= miss_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign branch_cnt_o = branch_cnt_reg;
  assign miss_cnt_o   = miss_cnt_reg;

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Consumes the fetch-stage decode result: the decoded next PC and the branch flag.
- Adds a direction prediction from a table of 2-bit saturating counters and produces the final predicted next PC for fetch.
- Sits between the fetch-side instruction parser and the PC register.
- Receives resolution updates from the execute stage.
- Keeps branch and mispredict statistics.

Parameters:
- INDEX_WIDTH, 6, log2 of counter-table entries (64).
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- pc_i  input  32  PC of the instruction in fetch
- parser_pc_next_i  input  32  decoded next PC: jump target, branch target, or pc+4
- is_branch_i  input  1  instruction is a conditional branch (BEQ/BNE)
- pc_next_o  output  32  predicted next PC
- pred_taken_o  output  1  predicted taken (0 when is_branch_i=0)
- pred_index_o  output  INDEX_WIDTH  table index used; carried down the pipeline
- update_en_i  input  1  resolved conditional branch this cycle
- update_index_i  input  INDEX_WIDTH  pred_index_o value of the resolved branch
- update_taken_i  input  1  actual outcome
- mispredict_i  input  1  resolved direction differed from prediction (qualified by update_en_i)
- branch_cnt_o  output  CNT_WIDTH  resolved branches
- miss_cnt_o  output  CNT_WIDTH  mispredicted branches

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset state:
  - All 2^INDEX_WIDTH counters = 2'b01 (weakly not-taken).
  - branch_cnt_o = 0, miss_cnt_o = 0.
  - Global history = 0 (GSHARE_EN build only).
  - Combinational outputs follow their inputs during reset using the reset table state.
- Index:
  - Without GSHARE_EN: idx = pc_i[INDEX_WIDTH+1:2].
  - pred_index_o = idx.
- Prediction (combinational, zero latency):
  - pred_taken_o = is_branch_i & table[idx][1].
  - pc_next_o = (is_branch_i & ~table[idx][1]) ? pc_i + 4 : parser_pc_next_i.
  - Jumps and non-branches therefore pass parser_pc_next_i through unchanged.
  - pc_i + 4 wraps modulo 2^32.
- Update (registered, at clk_i rising edge when update_en_i=1):
  - If update_taken_i: table[update_index_i] increments, saturating at 2'b11.
  - Else: it decrements, saturating at 2'b00.
  - update_en_i=0: no table or counter change; update_taken_i and mispredict_i are ignored.
- Read/write same index in the same cycle: the prediction uses the pre-update value. No bypass.
- Statistics:
  - branch_cnt_o += 1 on each update_en_i.
  - miss_cnt_o += 1 when update_en_i & mispredict_i.
  - Both wrap at 2^CNT_WIDTH with no saturation.
- Reset asserted mid-operation restores the full reset state immediately. Updates in flight are lost.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- Defined:
  - Adds an INDEX_WIDTH-bit global history register ghr.
  - idx = pc_i[INDEX_WIDTH+1:2] ^ ghr.
  - On update_en_i: ghr <= {ghr[INDEX_WIDTH-2:0], update_taken_i}. History is non-speculative, updated at resolution.
  - Updates still use update_index_i as supplied.
- Undefined:
  - No history register.
  - Index is the PC bits only.
  - Behaviour otherwise identical.

Decomposition:
- Shared package bp_pkg:
  - Counter typedef (2-bit).
  - Constants CNT_SNT=2'b00, CNT_WNT=2'b01, CNT_WT=2'b10, CNT_ST=2'b11.
  - Default INDEX_WIDTH.
- Sub-module sat_counter2: a combinational next-state function (counter, taken) -> counter, used by the table update.
- Table, statistics and history stay in bht_predictor.

Test Plan:
- Reset, then pc_i=0x00400010, is_branch_i=1, parser_pc_next_i=0x00400040 -> pred_taken_o=0, pc_next_o=0x00400014, pred_index_o=4; counters read 0.
- Two updates at index 4 with taken=1, then the same fetch -> after the first update the prediction is taken and pc_next_o=0x00400040. Three further taken updates keep the counter at 2'b11. One not-taken update returns 2'b10, still predicted taken.
- Jump: is_branch_i=0, parser_pc_next_i=0x00400100 -> pc_next_o=0x00400100, pred_taken_o=0, regardless of table state.
- Same-cycle update and read at index 4, with the counter at 01 and update taken -> this cycle predicts not-taken; the next cycle predicts taken.
- Five updates with mispredict_i on updates 2 and 5, plus update_en_i=0 cycles with mispredict_i=1 -> branch_cnt_o=5, miss_cnt_o=2. Assert rst_ni asynchronously mid-sequence -> both read 0 and the table returns to 01 without a clock edge.
- BHT_GSHARE_EN: after taken updates ghr=6'b000011; pc_i=0x00400010 -> pred_index_o=4^3=7.
